// File: rtl/syscall_out_ctrl.sv
// rtl/syscall_out_ctrl.sv - syscall print/exit controller with queued 8-digit hex display
// Optional feature macro: SYSOUT_HALT_EN (service 10 halts the CPU when defined).
module syscall_out_ctrl #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int SCAN_DIV    = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WE,
  input  logic [4:0]  RW,
  input  logic [31:0] result,
  input  logic        syscall,
  output logic        stall,
  output logic        halt,
  output logic [31:0] disp_value,
  output logic [7:0]  an,
  output logic [7:0]  seg
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t        state;
  logic [31:0]   v0, a0, last_val;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   eff_v0, eff_a0;
  logic          print, full, push, pop;

  // Same-cycle writeback bypass so a syscall sees the value being written right now
  assign eff_v0 = (WE && RW == 5'd2) ? result : v0;
  assign eff_a0 = (WE && RW == 5'd4) ? result : a0;

  assign print = syscall & ~halt & (eff_v0 == 32'd34);
  assign full  = (count == (AW+1)'(DEPTH));
  assign stall = print & full;
  assign push  = print & ~full;
  assign pop   = (state == S_HOLD) && (hold_cnt == HW'(HOLD_CYCLES - 1));

  assign disp_value = (state == S_HOLD) ? mem[rd_ptr] : last_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= '0;
      a0 <= '0;
    end else if (WE) begin
      if (RW == 5'd2) v0 <= result;
      if (RW == 5'd4) a0 <= result;
    end
  end

`ifdef SYSOUT_HALT_EN
  logic halt_q;
  logic do_exit;

  assign do_exit = syscall & ~halt_q & (eff_v0 == 32'd10);
  assign halt    = halt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       halt_q <= 1'b0;
    else if (do_exit) halt_q <= 1'b1;
  end
`else
  assign halt = 1'b0;
`endif

  // Queue and drain FSM; a pop never frees room for a same-cycle push since full uses the old count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      hold_cnt <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_val <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= eff_a0;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_val <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        S_EMPTY: begin
          hold_cnt <= '0;
          if (count != '0) state <= S_HOLD;
        end
        S_HOLD: begin
          if (pop) begin
            hold_cnt <= '0;
            if (count == (AW+1)'(1) && !push) state <= S_EMPTY;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  endfunction

  // an/seg are registered from idx, so they trail the prescaler wrap by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      an    <= 8'hFE;
      seg   <= 8'hC0;
    end else begin
      if (presc == SW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      an  <= ~(8'b1 << idx);
      seg <= glyph(disp_value[{idx, 2'b00} +: 4]);
    end
  end
endmodule

// File: tb/tb_syscall_out_ctrl.sv
// tb/tb_syscall_out_ctrl.sv - directed self-checking bench for syscall_out_ctrl
module tb_syscall_out_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        WE = 1'b0;
  logic [4:0]  RW = '0;
  logic [31:0] result = '0;
  logic        syscall = 1'b0;
  logic        stall, halt;
  logic [31:0] disp_value;
  logic [7:0]  an, seg;

  int vectors = 0;
  int errors  = 0;

  syscall_out_ctrl #(.DEPTH(4), .HOLD_CYCLES(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .WE(WE), .RW(RW), .result(result), .syscall(syscall),
    .stall(stall), .halt(halt), .disp_value(disp_value), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    WE = 1'b1; RW = r; result = v;
    tick();
    WE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    vectors++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt); end
    vectors++; if (disp_value !== 32'h0) begin errors++; $display("FAIL reset_disp: got %h expected 00000000", disp_value); end
    vectors++; if (an !== 8'hFE) begin errors++; $display("FAIL reset_an: got %h expected fe", an); end
    vectors++; if (seg !== 8'hC0) begin errors++; $display("FAIL reset_seg: got %h expected c0", seg); end
    tick();
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_print();
    wb(5'd2, 32'd34);
    wb(5'd4, 32'h12345678);
    syscall = 1'b1;
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL print_stall: got %b expected 0", stall); end
    tick();
    syscall = 1'b0;
    @(negedge clk);
    vectors++; if (disp_value !== 32'h0) begin errors++; $display("FAIL print_pre: got %h expected 00000000", disp_value); end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      vectors++; if (disp_value !== 32'h12345678) begin errors++; $display("FAIL print_hold%0d: got %h expected 12345678", k, disp_value); end
    end
    tick();
    @(negedge clk);
    vectors++; if (disp_value !== 32'h12345678) begin errors++; $display("FAIL print_empty_last: got %h expected 12345678", disp_value); end
    idle(4);
  endtask

  task automatic test_bypass();
    wb(5'd4, 32'h0);
    syscall = 1'b1; WE = 1'b1; RW = 5'd4; result = 32'hDEAD;
    tick();
    syscall = 1'b0; WE = 1'b0;
    @(negedge clk);
    vectors++; if (disp_value !== 32'h12345678) begin errors++; $display("FAIL bypass_pre: got %h expected 12345678", disp_value); end
    tick();
    @(negedge clk);
    vectors++; if (disp_value !== 32'h0000DEAD) begin errors++; $display("FAIL bypass_value: got %h expected 0000dead", disp_value); end
    idle(8);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [5];
    logic [31:0] samp [50];
    logic [31:0] rv [16];
    int          rl [16];
    int          nr;
    vals[0] = 32'hA0000001; vals[1] = 32'hA0000002; vals[2] = 32'hA0000003;
    vals[3] = 32'hA0000004; vals[4] = 32'hA0000005;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          int  stalls;
          logic s;
          syscall = 1'b1; WE = 1'b1; RW = 5'd4; result = vals[i];
          stalls = 0;
          for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            s = stall;
            tick();
            if (!s) break;
            stalls++;
          end
          vectors++;
          if (stalls !== ((i == 4) ? 2 : 0)) begin
            errors++; $display("FAIL b2b_stall_cycles%0d: got %0d expected %0d", i, stalls, (i == 4) ? 2 : 0);
          end
        end
        syscall = 1'b0; WE = 1'b0;
      end
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          samp[k] = disp_value;
        end
      end
    join
    nr = 1; rv[0] = samp[0]; rl[0] = 1;
    for (int k = 1; k < 50; k++) begin
      if (samp[k] === rv[nr-1]) rl[nr-1]++;
      else if (nr < 16) begin rv[nr] = samp[k]; rl[nr] = 1; nr++; end
    end
    vectors++; if (nr !== 6) begin errors++; $display("FAIL b2b_runs: got %0d expected 6", nr); end
    for (int j = 1; j < 6; j++) begin
      if (j < nr) begin
        vectors++;
        if (rv[j] !== vals[j-1]) begin errors++; $display("FAIL b2b_order%0d: got %h expected %h", j, rv[j], vals[j-1]); end
        if (j < 5) begin
          vectors++;
          if (rl[j] !== 4) begin errors++; $display("FAIL b2b_hold%0d: got %0d expected 4", j, rl[j]); end
        end
      end
    end
    idle(4);
  endtask

  task automatic test_scan();
    logic [7:0] exp_seg [8];
    logic [7:0] an_s [24];
    logic [7:0] seg_s [24];
    int idx, pidx, run, steps;
    exp_seg[0] = 8'h8E; exp_seg[1] = 8'h86; exp_seg[2] = 8'hA1; exp_seg[3] = 8'hC6;
    exp_seg[4] = 8'h83; exp_seg[5] = 8'h88; exp_seg[6] = 8'h90; exp_seg[7] = 8'h80;
    syscall = 1'b1; WE = 1'b1; RW = 5'd4; result = 32'h89ABCDEF;
    tick();
    syscall = 1'b0; WE = 1'b0;
    idle(8);
    @(negedge clk);
    vectors++; if (disp_value !== 32'h89ABCDEF) begin errors++; $display("FAIL scan_disp: got %h expected 89abcdef", disp_value); end
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      an_s[k] = an; seg_s[k] = seg;
    end
    pidx = -1; run = 0; steps = 0;
    for (int k = 0; k < 24; k++) begin
      idx = -1;
      for (int d = 0; d < 8; d++) if (an_s[k] === ~(8'b1 << d)) idx = d;
      vectors++;
      if (idx < 0) begin
        errors++; $display("FAIL scan_an_onehot%0d: got %h expected one-hot-low", k, an_s[k]);
      end else begin
        if (seg_s[k] !== exp_seg[idx]) begin
          errors++; $display("FAIL scan_seg%0d: got %h expected %h", k, seg_s[k], exp_seg[idx]);
        end
        if (pidx >= 0 && idx != pidx) begin
          vectors++;
          if (idx != ((pidx + 1) % 8)) begin errors++; $display("FAIL scan_step%0d: got digit %0d expected %0d", k, idx, (pidx + 1) % 8); end
          if (steps > 0) begin
            vectors++;
            if (run !== 2) begin errors++; $display("FAIL scan_dwell%0d: got %0d expected 2", k, run); end
          end
          steps++; run = 1;
        end else begin
          run++;
        end
        pidx = idx;
      end
    end
    vectors++; if (steps < 8) begin errors++; $display("FAIL scan_wrap: got %0d steps expected at least 8", steps); end
    tick();
  endtask

  task automatic test_mid_reset();
    wb(5'd2, 32'd34);
    for (int i = 0; i < 3; i++) begin
      syscall = 1'b1; WE = 1'b1; RW = 5'd4; result = 32'hC0DE0000 + i;
      tick();
    end
    syscall = 1'b1; WE = 1'b1; RW = 5'd2; result = 32'd10;
    tick();
    syscall = 1'b0; WE = 1'b0;
    @(negedge clk);
    vectors++; if (disp_value !== 32'hC0DE0000) begin errors++; $display("FAIL mrst_head: got %h expected c0de0000", disp_value); end
`ifdef SYSOUT_HALT_EN
    vectors++; if (halt !== 1'b1) begin errors++; $display("FAIL mrst_halt_pre: got %b expected 1", halt); end
`endif
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (disp_value !== 32'h0) begin errors++; $display("FAIL mrst_disp: got %h expected 00000000", disp_value); end
    vectors++; if (halt !== 1'b0) begin errors++; $display("FAIL mrst_halt: got %b expected 0", halt); end
    vectors++; if (an !== 8'hFE) begin errors++; $display("FAIL mrst_an: got %h expected fe", an); end
    vectors++; if (seg !== 8'hC0) begin errors++; $display("FAIL mrst_seg: got %h expected c0", seg); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++; if (disp_value !== 32'h0) begin errors++; $display("FAIL mrst_empty%0d: got %h expected 00000000", k, disp_value); end
      tick();
    end
    wb(5'd2, 32'd34);
    syscall = 1'b1; WE = 1'b1; RW = 5'd4; result = 32'h77;
    tick();
    syscall = 1'b0; WE = 1'b0;
    @(negedge clk);
    vectors++; if (disp_value !== 32'h0) begin errors++; $display("FAIL mrst_post_pre: got %h expected 00000000", disp_value); end
    tick();
    @(negedge clk);
    vectors++; if (disp_value !== 32'h77) begin errors++; $display("FAIL mrst_post_push: got %h expected 00000077", disp_value); end
    idle(8);
  endtask

  task automatic test_halt();
    wb(5'd2, 32'd10);
    syscall = 1'b1;
    @(negedge clk);
    vectors++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_pre: got %b expected 0", halt); end
    tick();
    syscall = 1'b0;
    @(negedge clk);
`ifdef SYSOUT_HALT_EN
    vectors++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halt); end
`else
    vectors++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_off: got %b expected 0", halt); end
`endif
    idle(3);
    wb(5'd2, 32'd34);
    syscall = 1'b1; WE = 1'b1; RW = 5'd4; result = 32'h0BADF00D;
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL halt_print_stall: got %b expected 0", stall); end
    tick();
    syscall = 1'b0; WE = 1'b0;
    tick();
    @(negedge clk);
`ifdef SYSOUT_HALT_EN
    vectors++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", halt); end
    vectors++; if (disp_value !== 32'h77) begin errors++; $display("FAIL halt_print_ignored: got %h expected 00000077", disp_value); end
`else
    vectors++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_off_later: got %b expected 0", halt); end
    vectors++; if (disp_value !== 32'h0BADF00D) begin errors++; $display("FAIL halt_off_print: got %h expected 0badf00d", disp_value); end
`endif
    idle(6);
  endtask

  initial begin
    test_reset();
    test_print();
    test_bypass();
    test_back_to_back();
    test_scan();
    test_mid_reset();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end
endmodule
